// File: rtl/knn_ctrl.sv
// ============================================================================
// Module   : knn_ctrl
// Brief    : K=4 nearest-neighbour sequencer: distances -> sorter -> vote.
// Revision : 1.0
// ============================================================================
`default_nettype none

module knn_ctrl #(
  parameter int COORD_W = 15,
  parameter int ADDR_W  = 8,
  parameter int LABEL_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [ADDR_W:0]    num_pts_i,
  input  logic [COORD_W-1:0] test_x_i,
  input  logic [COORD_W-1:0] test_y_i,
  output logic               mem_en_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic [COORD_W-1:0] mem_x_i,
  input  logic [COORD_W-1:0] mem_y_i,
  input  logic [LABEL_W-1:0] mem_label_i,
  output logic               sort_clr_o,
  output logic               sort_ready_o,
  output logic               sort_done_o,
  output logic [31:0]        sort_data_o,
  input  logic [ADDR_W-1:0]  sort_idx0_i,
  input  logic [ADDR_W-1:0]  sort_idx1_i,
  input  logic [ADDR_W-1:0]  sort_idx2_i,
  input  logic [ADDR_W-1:0]  sort_idx3_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [LABEL_W-1:0] result_label_o
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLEAR  = 4'd1,
    FETCH  = 4'd2,
    CALC   = 4'd3,
    FEED   = 4'd4,
    LRD    = 4'd5,
    LCAP   = 4'd6,
    VOTE   = 4'd7,
    FINISH = 4'd8
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W:0]         n_q, n_d;
  logic [COORD_W-1:0]      tx_q, tx_d, ty_q, ty_d;
  logic [ADDR_W-1:0]       p_q, p_d;
  logic [1:0]              r_q, r_d;
  logic [31:0]             dist_q, dist_d;
  logic [3:0][LABEL_W-1:0] lab_q, lab_d;
  logic [LABEL_W-1:0]      result_q, result_d;

  logic [COORD_W-1:0]      dx_w, dy_w;
  logic [2*COORD_W-1:0]    dx2_w, dy2_w;
  logic [31:0]             dist_w;
  logic [3:0][ADDR_W-1:0]  idx_w;
  logic [3:0]              valid_w;
  logic [3:0][2:0]         cnt_w;
  logic [2:0]              best_w;
  logic [LABEL_W-1:0]      win_w;

  assign idx_w = {sort_idx3_i, sort_idx2_i, sort_idx1_i, sort_idx0_i};

  always_comb begin
    dx_w   = (mem_x_i >= tx_q) ? (mem_x_i - tx_q) : (tx_q - mem_x_i);
    dy_w   = (mem_y_i >= ty_q) ? (mem_y_i - ty_q) : (ty_q - mem_y_i);
    dx2_w  = dx_w * dx_w;
    dy2_w  = dy_w * dy_w;
    dist_w = 32'(dx2_w) + 32'(dy2_w);
  end

  // Majority vote over the valid ranks; strict '>' keeps the nearest rank on ties.
  always_comb begin
    valid_w = '0;
    cnt_w   = '0;
    for (int i = 0; i < 4; i++) begin
      valid_w[i] = (n_q > (ADDR_W+1)'(i));
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (valid_w[j] && (lab_q[j] == lab_q[i])) begin
          cnt_w[i] = cnt_w[i] + 3'd1;
        end
      end
    end
    win_w  = lab_q[0];
    best_w = cnt_w[0];
    for (int i = 1; i < 4; i++) begin
      if (valid_w[i] && (cnt_w[i] > best_w)) begin
        best_w = cnt_w[i];
        win_w  = lab_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    p_d          = p_q;
    r_d          = r_q;
    dist_d       = dist_q;
    lab_d        = lab_q;
    result_d     = result_q;
    mem_en_o     = 1'b0;
    mem_addr_o   = '0;
    sort_clr_o   = 1'b0;
    sort_ready_o = 1'b0;
    sort_done_o  = 1'b1;
    sort_data_o  = '0;
    done_o       = 1'b0;
    busy_o       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d     = num_pts_i;
          tx_d    = test_x_i;
          ty_d    = test_y_i;
          p_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        sort_clr_o = 1'b1;
        if (n_q == '0) begin
          result_d = '0;
          state_d  = FINISH;
        end else begin
          state_d  = FETCH;
        end
      end
      FETCH: begin
        mem_en_o   = 1'b1;
        mem_addr_o = p_q;
        state_d    = CALC;
      end
      CALC: begin
        dist_d  = dist_w;
        state_d = FEED;
      end
      FEED: begin
        sort_ready_o = 1'b1;
        sort_done_o  = 1'b0;
        sort_data_o  = dist_q;
        p_d          = p_q + ADDR_W'(1);
        if ({1'b0, p_q} == (n_q - (ADDR_W+1)'(1))) begin
          r_d     = 2'd0;
          state_d = LRD;
        end else begin
          state_d = FETCH;
        end
      end
      LRD: begin
        mem_en_o   = 1'b1;
        mem_addr_o = idx_w[r_q];
        state_d    = LCAP;
      end
      LCAP: begin
        lab_d[r_q] = mem_label_i;
        r_d        = r_q + 2'd1;
        state_d    = (r_q == 2'd3) ? VOTE : LRD;
      end
      VOTE: begin
        result_d = win_w;
        state_d  = FINISH;
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q      <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      p_q      <= '0;
      r_q      <= '0;
      dist_q   <= '0;
      lab_q    <= '0;
      result_q <= '0;
    end else begin
      n_q      <= n_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      p_q      <= p_d;
      r_q      <= r_d;
      dist_q   <= dist_d;
      lab_q    <= lab_d;
      result_q <= result_d;
    end
  end

  assign result_label_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_knn_ctrl.sv
// ============================================================================
// Module   : tb_knn_ctrl
// Brief    : Bench for knn_ctrl with point-memory and insertion-sorter models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_knn_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  num_pts = '0;
  logic [14:0] test_x = '0, test_y = '0;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [14:0] mem_x = '0, mem_y = '0;
  logic [3:0]  mem_label = '0;
  logic        sort_clr, sort_ready, sort_done;
  logic [31:0] sort_data;
  logic [3:0][7:0]  sd_idx  = '0;
  logic [3:0][31:0] sd_dist = {4{32'hFFFF_FFFF}};
  logic [7:0]  sd_cnt = '0;
  logic        busy, done;
  logic [3:0]  result_label;

  knn_ctrl #(.COORD_W(15), .ADDR_W(8), .LABEL_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_pts_i(num_pts),
    .test_x_i(test_x), .test_y_i(test_y),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr),
    .mem_x_i(mem_x), .mem_y_i(mem_y), .mem_label_i(mem_label),
    .sort_clr_o(sort_clr), .sort_ready_o(sort_ready), .sort_done_o(sort_done),
    .sort_data_o(sort_data),
    .sort_idx0_i(sd_idx[0]), .sort_idx1_i(sd_idx[1]),
    .sort_idx2_i(sd_idx[2]), .sort_idx3_i(sd_idx[3]),
    .busy_o(busy), .done_o(done), .result_label_o(result_label)
  );

  always #5 clk = ~clk;

  int px[256], py[256], pl[256];
  int ref_rk[4];
  int n_cmp = 0, n_bad = 0;
  int prev_res = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DUT outputs sampled mid-cycle, consumed by the models on the next rising edge
  logic       en_s = 0, clr_s = 0, rdy_s = 0, sdone_s = 1;
  logic [7:0] addr_s = 0;
  logic [31:0] data_s = 0;
  always @(negedge clk) begin
    en_s <= mem_en; addr_s <= mem_addr; clr_s <= sort_clr;
    rdy_s <= sort_ready; sdone_s <= sort_done; data_s <= sort_data;
  end

  always @(negedge clk) begin
    if (sort_clr || sort_ready) chk("clr_and_ready_exclusive", sort_clr & sort_ready, 0);
    if (sort_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sort_data_extra: got %0d, expected no feed", sort_data);
      end else begin
        chk("sort_data", sort_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (en_s) begin
      mem_x     <= px[addr_s][14:0];
      mem_y     <= py[addr_s][14:0];
      mem_label <= pl[addr_s][3:0];
    end
  end

  // Stable insertion sorter: equal distances keep arrival order
  always @(posedge clk) begin : sorter_model
    logic [3:0][31:0] d;
    logic [3:0][7:0]  ix;
    int k;
    d = sd_dist; ix = sd_idx;
    if (clr_s) begin
      sd_dist <= {4{32'hFFFF_FFFF}};
      sd_idx  <= '0;
      sd_cnt  <= '0;
    end else if (rdy_s) begin
      k = 4;
      for (int i = 3; i >= 0; i--) if (data_s < d[i]) k = i;
      for (int i = 3; i > k; i--) begin d[i] = d[i-1]; ix[i] = ix[i-1]; end
      if (k < 4) begin d[k] = data_s; ix[k] = sd_cnt; end
      sd_dist <= d;
      sd_idx  <= ix;
      if (!sdone_s) sd_cnt <= sd_cnt + 8'd1;
    end
  end

  function automatic longint pdist(input int i, input int tx, input int ty);
    longint dx, dy;
    dx = (px[i] > tx) ? px[i] - tx : tx - px[i];
    dy = (py[i] > ty) ? py[i] - ty : ty - py[i];
    return dx*dx + dy*dy;
  endfunction

  // Reference: pick 4 nearest (ties -> lower index), histogram labels, earliest rank wins ties
  task automatic ref_model(input int n, input int tx, input int ty, output int lab);
    bit used[256];
    int hist[16];
    int best, bi;
    for (int i = 0; i < 256; i++) used[i] = 0;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    for (int r = 0; r < 4; r++) begin
      ref_rk[r] = 0;
      if (r < n) begin
        bi = -1;
        for (int i = 0; i < n; i++)
          if (!used[i] && (bi < 0 || pdist(i, tx, ty) < pdist(bi, tx, ty))) bi = i;
        used[bi] = 1;
        ref_rk[r] = bi;
        hist[pl[bi]]++;
      end
    end
    lab = 0; best = 0;
    for (int r = 0; r < 4 && r < n; r++)
      if (hist[pl[ref_rk[r]]] > best) begin best = hist[pl[ref_rk[r]]]; lab = pl[ref_rk[r]]; end
  endtask

  task automatic run_op(input int n, input int tx, input int ty, input int glitch,
                        input int exp_lab_in, input int exp_lat_in);
    int exp_lab, exp_lat, lat, clr_cnt, glitched, exp_en, exp_addr;
    bit got;
    ref_model(n, tx, ty, exp_lab);
    if (exp_lab_in >= 0) exp_lab = exp_lab_in;
    exp_lat = (exp_lat_in >= 0) ? exp_lat_in : ((n == 0) ? 2 : 3*n + 11);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(32'(pdist(i, tx, ty)));
    @(negedge clk);
    start = 1; num_pts = 9'(n); test_x = 15'(tx); test_y = 15'(ty);
    lat = 0; clr_cnt = 0; glitched = 0; got = 0;
    while (!got && lat < exp_lat + 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("result_held", result_label, prev_res);
      end
      if (glitched == 1) begin start = 0; glitched = 2; end
      if (glitch != 0 && glitched == 0 && sort_ready) begin
        start = 1; num_pts = 9'd1; test_x = 15'd32767; test_y = 15'd32767; glitched = 1;
      end
      if (sort_clr) clr_cnt++;
      exp_en = 0; exp_addr = 0;
      if (n > 0 && lat >= 2 && lat < 3*n + 2 && (lat - 2) % 3 == 0) begin
        exp_en = 1; exp_addr = ((lat - 2) / 3) % 256;
      end else if (n > 0 && lat >= 3*n + 2 && lat < 3*n + 10 && (lat - 3*n - 2) % 2 == 0) begin
        exp_en = 1; exp_addr = ref_rk[(lat - 3*n - 2) / 2];
      end
      if (exp_en != 0 || mem_en) chk("mem_en", mem_en, exp_en);
      if (exp_en != 0) chk("mem_addr", mem_addr, exp_addr);
      if (done) got = 1;
    end
    if (!got) $display("FAIL done_timeout: no done within %0d cycles", lat);
    chk("done_latency", lat, exp_lat);
    chk("result_label", result_label, exp_lab);
    chk("sort_clr_pulses", clr_cnt, 1);
    chk("feeds_outstanding", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_after_done", {done, busy}, 0);
    prev_res = exp_lab;
  endtask

  typedef struct packed {
    logic [8:0]        n;
    logic [14:0]       tx, ty;
    logic [5:0][14:0]  x, y;
    logic [5:0][3:0]   l;
    logic [3:0]        lab;
    logic [15:0]       lat;
    logic              glitch;
  } vec_t;
  vec_t vt[5];

  task automatic setp(input int v, input int i, input int x, input int y, input int l);
    vt[v].x[i] = 15'(x); vt[v].y[i] = 15'(y); vt[v].l[i] = 4'(l);
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < 256; i++) begin px[i] = 0; py[i] = 0; pl[i] = 0; end
    for (int i = 0; i < 6; i++) begin
      px[i] = int'(vt[v].x[i]); py[i] = int'(vt[v].y[i]); pl[i] = int'(vt[v].l[i]);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, n, sm, tx, ty, lab;
    vt[0] = '0; vt[1] = '0; vt[2] = '0; vt[3] = '0; vt[4] = '0;
    vt[0].n = 6; vt[0].lab = 3; vt[0].lat = 29;
    setp(0,0,10,0,1); setp(0,1,1,1,2); setp(0,2,2,0,2);
    setp(0,3,0,3,3); setp(0,4,50,50,1); setp(0,5,1,0,3);
    vt[1].n = 2; vt[1].lab = 7; vt[1].lat = 17;
    setp(1,0,1,0,7); setp(1,1,0,2,5);
    vt[2].n = 1; vt[2].lab = 6; vt[2].lat = 14;
    setp(2,0,32767,32767,6);
    vt[3].n = 5; vt[3].tx = 100; vt[3].ty = 200; vt[3].lab = 2; vt[3].lat = 26;
    setp(3,0,90,200,1); setp(3,1,100,203,2); setp(3,2,105,205,2);
    setp(3,3,300,0,1); setp(3,4,99,199,5);
    vt[4].n = 3; vt[4].tx = 5; vt[4].ty = 5; vt[4].lab = 8; vt[4].lat = 20; vt[4].glitch = 1;
    setp(4,0,0,0,1); setp(4,1,5,6,8); setp(4,2,7,5,9);

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {mem_en, mem_addr, sort_clr, sort_ready, sort_done, sort_data, busy, done, result_label},
        64'd1 << 38);
    rst_n = 1;

    load_vec(0);
    run_op(0, 0, 0, 0, 0, 2);

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_op(int'(vt[v].n), int'(vt[v].tx), int'(vt[v].ty), int'(vt[v].glitch),
             int'(vt[v].lab), int'(vt[v].lat));
    end

    run_op(0, 0, 0, 0, 0, 2);

    // Reset during the first FETCH: abort, no done, then a clean rerun
    load_vec(0);
    @(negedge clk);
    start = 1; num_pts = 9'd6; test_x = 0; test_y = 0;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("fetch_before_reset", mem_en, 1);
    rst_n = 0;
    #1;
    chk("reset_mid_op", {busy, mem_en, sort_done, done, sort_ready, result_label}, 9'b001000000);
    repeat (3) @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    prev_res = 0;
    nd = 0;
    repeat (12) begin @(negedge clk); if (done || busy) nd++; end
    chk("quiet_after_reset", nd, 0);
    run_op(6, 0, 0, 0, 3, 29);

    // N=256: labels 9 except the four nearest
    for (int i = 0; i < 256; i++) begin px[i] = i + 10; py[i] = 0; pl[i] = 9; end
    px[100] = 0; px[150] = 1; px[200] = 2; px[255] = 3;
    pl[100] = 4; pl[150] = 4; pl[200] = 4; pl[255] = 4;
    run_op(256, 0, 0, 0, 4, 779);

    for (int t = 0; t < 20; t++) begin
      n  = $urandom_range(0, 20);
      sm = $urandom_range(0, 1);
      for (int i = 0; i < 256; i++) begin
        px[i] = sm ? $urandom_range(0, 15) : $urandom_range(0, 32767);
        py[i] = sm ? $urandom_range(0, 15) : $urandom_range(0, 32767);
        pl[i] = sm ? $urandom_range(0, 2)  : $urandom_range(0, 15);
      end
      tx = sm ? $urandom_range(0, 15) : $urandom_range(0, 32767);
      ty = sm ? $urandom_range(0, 15) : $urandom_range(0, 32767);
      ref_model(n, tx, ty, lab);
      run_op(n, tx, ty, 0, lab, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
- Sequencer for one k-NN classification with K=4: fetches N training points from a point memory and computes the squared Euclidean distance of each to a test point.
- Streams the distances into the existing 4-entry insertion sorter, then reads back the sorter's 4 nearest indices and fetches their labels.
- Resolves the majority vote and reports the winning label.
- Sits between the CPU-facing register bank (start, num_pts, test point, result) and the sorter and point memory.

Parameters:
- COORD_W, 15, unsigned coordinate width; guarantees dx^2+dy^2 < 2^31, fitting in the 32-bit sorter word.
- ADDR_W, 8, point-memory address width; equals the sorter index width (32/4).
- LABEL_W, 4, class label width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request, honoured only in IDLE
- num_pts  in  ADDR_W+1  number of training points N (0..256), sampled at start
- test_x, test_y  in  COORD_W  test point, sampled at start
- mem_en  out  1  point-memory read enable
- mem_addr  out  ADDR_W  point-memory address
- mem_x, mem_y  in  COORD_W  point coordinates, valid 1 cycle after mem_en
- mem_label  in  LABEL_W  point label, valid 1 cycle after mem_en
- sort_clr  out  1  sorter clear pulse; resets the sorter registers and index counter
- sort_ready  out  1  sorter load strobe
- sort_done  out  1  sorter index-write inhibit
- sort_data  out  32  distance to sorter
- sort_idx0..sort_idx3  in  ADDR_W each  sorter nearest-index outputs, rank 0 = nearest
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result_label  out  LABEL_W  winning label, held until the next start

Behaviour:
- Reset values: all outputs 0, except sort_done=1. FSM state is IDLE.
- FSM states: IDLE -> CLEAR -> {FETCH -> CALC -> FEED} x N -> {LRD -> LCAP} x 4 -> VOTE -> FINISH -> IDLE.
- IDLE:
  - On start=1, register num_pts, test_x and test_y; clear the point counter p; go to CLEAR.
  - busy=1 from the next cycle.
- CLEAR:
  - sort_clr=1 for exactly one cycle.
  - If N==0, go to FINISH with result_label=0. Otherwise go to FETCH.
- FETCH: mem_en=1, mem_addr=p.
- CALC:
  - dx=|mem_x-test_x|, dy=|mem_y-test_y|, each COORD_W bits.
  - Register dist = dx*dx + dy*dy, zero-extended to 32 bits. No overflow is possible.
- FEED:
  - sort_ready=1, sort_data=dist, sort_done=0, for one cycle.
  - p increments. If p==N-1 before the increment, go to LRD with rank r=0; otherwise go to FETCH.
- sort_done=1 and sort_ready=0 in every state other than FEED. The sorter index for point p therefore equals p.
- LRD: mem_en=1, mem_addr=sort_idx[r].
- LCAP:
  - lab[r] <= mem_label.
  - r increments. Go to LRD while r<3, else VOTE.
  - All 4 ranks are always read, regardless of N.
- VOTE: single cycle, combinational count, registered result.
  - Rank r is valid iff r < N.
  - For each valid rank, cnt[r] = number of valid ranks whose label equals lab[r].
  - Winner is the label with the highest cnt. Ties resolve to the lowest rank (the nearest neighbour) among the tied ranks.
  - result_label updates at the end of VOTE.
- FINISH: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Latency: done is high 3N+11 cycles after the start cycle for N>=1, and 2 cycles after for N==0.
- Boundary conditions:
  - start while busy is ignored; in-flight inputs are not resampled.
  - num_pts > 256 is impossible by width. N=256 wraps p to 0 after the last feed, which is harmless because the FSM leaves FEED.
  - result_label keeps its previous value from start until the end of VOTE.
  - Reset asserted mid-operation: the FSM goes to IDLE immediately and outputs take their reset values. The sorter is not cleared until the next CLEAR.
  - sort_clr and sort_ready are never high in the same cycle.

Test Plan:
- Reset with rst=0: all outputs 0, sort_done=1. Release rst, pulse start with N=0 -> sort_clr pulses, done 2 cycles later, result_label=0.
- test=(0,0), N=6, points (10,0,L1),(1,1,L2),(2,0,L2),(0,3,L3),(50,50,L1),(1,0,L3) -> sorter receives 100,2,4,9,5000,1 in order; indices read 5,1,2,3; labels L3,L2,L2,L3 -> result 3 (tie broken by rank 0); done at cycle 29.
- N=2, points (1,0,L7),(0,2,L5) -> ranks 2,3 masked; tie 1 vs 1 -> result 7.
- Max distance: test=(0,0), point (32767,32767) -> sort_data=0x7FFE0002, no overflow.
- start pulsed during FEED -> ignored; the single operation completes with unchanged latency. Reset pulsed mid-FETCH -> busy=0 and no done; a fresh start then runs correctly.
- N=256 with all labels 9 except nearest four labelled 4 -> result 4; p wraps cleanly; done at cycle 779.
